control_multiciclo: RTL and testbench

Multicycle main controller and ALU decoder for the ARMv4 core. It sits directly upstream of the conditional-execution logic.
- Decodes Op/Funct/Rd of the latched instruction.
- Sequences the datapath through fetch/decode/execute/writeback states.
- Produces the raw PCS, RegW, MemW and FlagW that the condition stage gates with CondEx.
- Produces datapath mux selects, NextPC and IRWrite directly.

---
 rtl/control_multiciclo_pkg.sv | 100 ++++++++++
 rtl/control_multiciclo_alu_decoder.sv | 49 ++++
 rtl/control_multiciclo.sv | 87 ++++++++
 tb/tb_control_multiciclo.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_multiciclo_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
// Holds the state enum, datapath select codes and the per-state Moore output table.
package control_multiciclo_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    typedef struct packed {
        logic       irwrite;
        logic       nextpc;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
        logic       regw;
        logic       memw;
        logic       branch;
    } ctrl_t;

    // Moore outputs of each state; anything not set here stays 0.
    function automatic ctrl_t moore_outs(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite   = 1'b1;
                c.nextpc    = 1'b1;
                c.alusrca   = 1'b1;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURES;
            end
            DECODE: begin
                c.alusrca   = 1'b1;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALURES;
            end
            MEMADR:   c.alusrcb = SRCB_IMM;
            MEMRD:    c.adrsrc  = 1'b1;
            MEMWB: begin
                c.resultsrc = RES_RDATA;
                c.regw      = 1'b1;
            end
            MEMWR: begin
                c.adrsrc = 1'b1;
                c.memw   = 1'b1;
            end
            EXECUTER: begin
                c.alusrcb = SRCB_WD;
                c.aluop   = 1'b1;
            end
            EXECUTEI: begin
                c.alusrcb = SRCB_IMM;
                c.aluop   = 1'b1;
            end
            ALUWB:    c.regw = 1'b1;
            BRANCH: begin
                c.alusrcb   = SRCB_IMM;
                c.resultsrc = RES_ALURES;
                c.branch    = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_multiciclo_alu_decoder.sv
// ALU decoder: maps cmd/S to ALUControl, flag-write enables and a no-writeback hint.
// Latency: purely combinational.
// Backpressure: none, follows its inputs.
module alu_decoder
    import control_multiciclo_pkg::*;
(
    input  logic [4:0] Funct,
    input  logic       ALUOp,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       NoWrite
);

    logic [1:0] dec_ctl;
    logic       known;
    logic       is_cmp;

    always_comb begin
        dec_ctl = ALU_ADD;
        known   = 1'b1;
        is_cmp  = 1'b0;
        case (Funct[4:1])
            CMD_ADD: dec_ctl = ALU_ADD;
            CMD_SUB: dec_ctl = ALU_SUB;
            CMD_AND: dec_ctl = ALU_AND;
            CMD_ORR: dec_ctl = ALU_ORR;
            CMD_CMP: begin
                dec_ctl = ALU_SUB;
                is_cmp  = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

    // NoWrite ignores ALUOp: it is consumed in ALUWB, where ALUOp is already low.
    always_comb begin
        ALUControl = ALU_ADD;
        FlagW      = 2'b00;
        NoWrite    = is_cmp | ~known;
        if (ALUOp) begin
            ALUControl = dec_ctl;
            if (is_cmp)
                FlagW = 2'b11;
            else if (known)
                FlagW = {Funct[0], Funct[0] & ((dec_ctl == ALU_ADD) | (dec_ctl == ALU_SUB))};
        end
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle main controller: sequences fetch/decode/execute/writeback and drives raw strobes.
// Latency: DP 4, LDR 5, STR 4, B 3, undefined 2 cycles; Moore outputs registered with the state.
// Backpressure: none, advances one state per clock; reset abandons the instruction.
module control_multiciclo
    import control_multiciclo_pkg::*;
#(
    parameter logic [3:0] PC_IDX = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic [1:0] FlagW,
    output logic       NextPC,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] state_o
);

    state_t     state;
    state_t     state_nxt;
    ctrl_t      ctl;
    logic [1:0] flagw_raw;
    logic       nowrite;

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: begin
                case (Op)
                    OP_MEM:  state_nxt = MEMADR;
                    OP_DP:   state_nxt = Funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   state_nxt = BRANCH;
                    default: state_nxt = FETCH;
                endcase
            end
            MEMADR:   state_nxt = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_nxt = MEMWB;
            EXECUTER: state_nxt = ALUWB;
            EXECUTEI: state_nxt = ALUWB;
            default:  state_nxt = FETCH;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
            ctl   <= moore_outs(FETCH);
        end else begin
            state <= state_nxt;
            ctl   <= moore_outs(state_nxt);
        end
    end

    alu_decoder u_alu_decoder (
        .Funct      (Funct[4:0]),
        .ALUOp      (ctl.aluop),
        .ALUControl (ALUControl),
        .FlagW      (flagw_raw),
        .NoWrite    (nowrite)
    );

    // Reset holds state at FETCH, whose table entry raises IRWrite/NextPC, so strobes are gated.
    assign IRWrite   = rst & ctl.irwrite;
    assign NextPC    = rst & ctl.nextpc;
    assign MemW      = rst & ctl.memw;
    assign RegW      = rst & ctl.regw & ~(nowrite & (state == ALUWB));
    assign FlagW     = rst ? flagw_raw : 2'b00;
    assign PCS       = rst & (ctl.branch | (RegW & (Rd == PC_IDX)));

    assign AdrSrc    = ctl.adrsrc;
    assign ALUSrcA   = ctl.alusrca;
    assign ALUSrcB   = ctl.alusrcb;
    assign ResultSrc = ctl.resultsrc;
    assign state_o   = state;

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: directed instructions checked cycle by cycle against a spec model.
module tb_control_multiciclo;
    import control_multiciclo_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic [3:0] Rd = 4'd0;
    logic       PCS, RegW, MemW, NextPC, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] FlagW, ALUSrcB, ResultSrc, ALUControl;
    logic [3:0] state_o;

    control_multiciclo dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .FlagW      (FlagW),
        .NextPC     (NextPC),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // Output bundle: {PCS,RegW,MemW,FlagW[1:0],NextPC,IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl}
    logic [14:0] outs;
    assign outs = {PCS, RegW, MemW, FlagW, NextPC, IRWrite, AdrSrc, ALUSrcA,
                   ALUSrcB, ResultSrc, ALUControl};

    typedef struct packed {
        state_t      st;
        logic [14:0] m;
        logic [14:0] v;
    } exp_t;

    typedef struct packed {
        logic [7:0]  idx;
        logic [14:0] m;
        logic [14:0] v;
    } pin_t;

    exp_t expq[$];
    pin_t pins[$];
    int   total = 0;
    int   bad = 0;
    logic done = 1'b0;

    function automatic logic [14:0] model(input state_t s, input logic [1:0] op,
                                          input logic [5:0] f, input logic [3:0] rd);
        logic       irw, npc, adr, srca, regw, memw, br, exe, known, cmp, sbit, pcs;
        logic [1:0] srcb, res, aluc, flg;
        logic [3:0] cmd;
        irw = 0; npc = 0; adr = 0; srca = 0; regw = 0; memw = 0; br = 0; exe = 0;
        srcb = 2'd0; res = 2'd0; aluc = 2'd0; flg = 2'd0;
        cmd   = f[4:1];
        sbit  = f[0];
        cmp   = (cmd == 4'd10);
        known = (cmd == 4'd4) || (cmd == 4'd2) || (cmd == 4'd0) || (cmd == 4'd12) || cmp;
        case (s)
            FETCH:    begin irw = 1; npc = 1; srca = 1; srcb = 2'd2; res = 2'd2; end
            DECODE:   begin srca = 1; srcb = 2'd2; res = 2'd2; end
            MEMADR:   srcb = 2'd1;
            MEMRD:    adr = 1;
            MEMWB:    begin res = 2'd1; regw = 1; end
            MEMWR:    begin adr = 1; memw = 1; end
            EXECUTER: exe = 1;
            EXECUTEI: begin exe = 1; srcb = 2'd1; end
            ALUWB:    regw = known && !cmp;
            BRANCH:   begin srcb = 2'd1; res = 2'd2; br = 1; end
            default:  ;
        endcase
        if (exe) begin
            if (cmd == 4'd2 || cmp) aluc = 2'd1;
            else if (cmd == 4'd0)   aluc = 2'd2;
            else if (cmd == 4'd12)  aluc = 2'd3;
            else                    aluc = 2'd0;
            if (cmp)         flg = 2'b11;
            else if (!known) flg = 2'b00;
            else             flg = {sbit, sbit & (aluc < 2'd2)};
        end
        pcs = br | (regw & (rd == 4'd15));
        unused_op(op);
        return {pcs, regw, memw, flg, npc, irw, adr, srca, srcb, res, aluc};
    endfunction

    function automatic void unused_op(input logic [1:0] op);
        if (op > 2'd3) $display("unreachable");
    endfunction

    // Single checker: reset-phase literals, per-cycle model compare, hand-computed pins.
    always @(negedge clk or negedge rst) begin
        exp_t        e;
        logic [14:0] em;
        if (!rst) begin
            #1;
            if (!rst) begin
                total++;
                if (state_o !== FETCH) begin
                    bad++;
                    $display("FAIL reset_state got=%0d exp=%0d", state_o, FETCH);
                end
                total++;
                if (outs !== 15'h0068) begin
                    bad++;
                    $display("FAIL reset_outs got=%h exp=%h", outs, 15'h0068);
                end
            end
        end else if (done) begin
            total++;
            if (expq.size() != 0) begin
                bad++;
                $display("FAIL leftover_expect got=%0d exp=0", expq.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end else if (expq.size() > 0) begin
            e  = expq.pop_front();
            em = model(e.st, Op, Funct, Rd);
            total++;
            if (state_o !== e.st) begin
                bad++;
                $display("FAIL state t=%0t got=%0d exp=%0d", $time, state_o, e.st);
            end
            total++;
            if (outs !== em) begin
                bad++;
                $display("FAIL outs st=%0d t=%0t got=%h exp=%h", e.st, $time, outs, em);
            end
            if (e.m != 15'd0) begin
                total++;
                if ((outs & e.m) !== e.v) begin
                    bad++;
                    $display("FAIL pin st=%0d mask=%h got=%h exp=%h", e.st, e.m, outs & e.m, e.v);
                end
            end
        end
    end

    task automatic pin(input int i, input logic [14:0] m, input logic [14:0] v);
        pins.push_back('{idx: 8'(i), m: m, v: v});
    endtask

    // Pushes the expected state walk (truncated to cut entries when cut>0) with attached pins.
    task automatic push_seq(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                            input int cut, output int n);
        state_t seq[$];
        exp_t   e;
        Op = op; Funct = f; Rd = rd;
        seq.push_back(FETCH);
        seq.push_back(DECODE);
        case (op)
            2'b00: begin seq.push_back(f[5] ? EXECUTEI : EXECUTER); seq.push_back(ALUWB); end
            2'b01: begin
                seq.push_back(MEMADR);
                if (f[0]) begin seq.push_back(MEMRD); seq.push_back(MEMWB); end
                else      seq.push_back(MEMWR);
            end
            2'b10: seq.push_back(BRANCH);
            default: ;
        endcase
        n = (cut > 0) ? cut : seq.size();
        for (int i = 0; i < n; i++) begin
            e = '{st: seq[i], m: 15'd0, v: 15'd0};
            foreach (pins[k]) if (int'(pins[k].idx) == i) begin
                e.m = e.m | pins[k].m;
                e.v = e.v | pins[k].v;
            end
            expq.push_back(e);
        end
        pins.delete();
    endtask

    task automatic run(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
        int n;
        push_seq(op, f, rd, 0, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        // ADDS R1,R2,R3
        pin(0, 15'h0300, 15'h0300);
        pin(2, 15'h0C03, 15'h0C00);
        pin(3, 15'h6000, 15'h2000);
        run(2'b00, 6'b001001, 4'd1);
        // LDR R15,[R0,#4]
        pin(3, 15'h0080, 15'h0080);
        pin(4, 15'h600C, 15'h6004);
        run(2'b01, 6'b011001, 4'd15);
        // STR
        pin(2, 15'h1030, 15'h0010);
        pin(3, 15'h1000, 15'h1000);
        run(2'b01, 6'b011000, 4'd2);
        // CMP
        pin(2, 15'h0C03, 15'h0C01);
        pin(3, 15'h6000, 15'h0000);
        run(2'b00, 6'b010101, 4'd0);
        // B
        pin(2, 15'h6030, 15'h4010);
        run(2'b10, 6'b101000, 4'd0);
        // Undefined op
        pin(1, 15'h7F00, 15'h0000);
        run(2'b11, 6'b000000, 4'd15);
        // SUB immediate, no S
        pin(2, 15'h0C33, 15'h0011);
        run(2'b00, 6'b100100, 4'd3);
        // ANDS
        pin(2, 15'h0C03, 15'h0802);
        run(2'b00, 6'b000001, 4'd5);
        // ORR into R15
        pin(2, 15'h0003, 15'h0003);
        pin(3, 15'h6000, 15'h6000);
        run(2'b00, 6'b011000, 4'd15);
        // Unsupported cmd with S into R15: no flags, no write
        pin(2, 15'h0C03, 15'h0000);
        pin(3, 15'h6000, 15'h0000);
        run(2'b00, 6'b011011, 4'd15);
        // STR aborted by reset during MEMADR
        pin(2, 15'h1000, 15'h0000);
        push_seq(2'b01, 6'b011000, 4'd2, 3, n);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        // ADD R4 right after release
        pin(0, 15'h0300, 15'h0300);
        pin(3, 15'h6000, 15'h2000);
        run(2'b00, 6'b001000, 4'd4);
        done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, got=timeout exp=finish");
        $fatal(1);
    end

endmodule
